// File: rtl/operand_display.sv
// operand_display: converts a 32-bit unsigned operand to BCD with a sequential
// double-dabble engine and drives an 8-digit multiplexed common-anode display.
// Optional feature macro: DISPLAY_LZB_EN (leading-zero blanking).
//
// state  | meaning
// IDLE   | waiting for load; display shows last committed value
// CONV   | 32 add-3/shift iterations of double dabble
// COMMIT | publish BCD result (or dash fill on overflow) to display buffer
module operand_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [31:0] value,
    input  logic        load,
    output logic        busy,
    output logic        overflow,
    output logic [6:0]  seg,
    output logic [7:0]  an
);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    localparam int               DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    // Digit code never produced by BCD; reserved to mean "show a dash".
    localparam logic [3:0]       DASH_DIGIT = 4'hF;

    state_t           state, state_nxt;
    logic [31:0]      bin_q;
    logic [39:0]      bcd_q;
    logic [39:0]      bcd_adj;
    logic [4:0]       iter_q;
    logic [31:0]      buf_q;
    logic             ovf_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       idx_q;
    logic [7:0]       blank;
    logic [3:0]       cur_digit;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:       seg_code = 7'h40;
            4'd1:       seg_code = 7'h79;
            4'd2:       seg_code = 7'h24;
            4'd3:       seg_code = 7'h30;
            4'd4:       seg_code = 7'h19;
            4'd5:       seg_code = 7'h12;
            4'd6:       seg_code = 7'h02;
            4'd7:       seg_code = 7'h78;
            4'd8:       seg_code = 7'h00;
            4'd9:       seg_code = 7'h10;
            DASH_DIGIT: seg_code = 7'h3F;
            default:    seg_code = 7'h7F;
        endcase
    endfunction

    assign busy      = (state != IDLE);
    assign overflow  = ovf_q;
    assign cur_digit = buf_q[{idx_q, 2'b00} +: 4];

    // FSM state register
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic; loads outside IDLE are simply not looked at
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = CONV;
            CONV:    if (iter_q == 5'd31) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Conversion datapath and double-buffered display register
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            iter_q <= '0;
            buf_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin_q  <= value;
                        bcd_q  <= '0;
                        iter_q <= '0;
                    end
                end
                CONV: begin
                    {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                    iter_q         <= iter_q + 5'd1;
                end
                COMMIT: begin
                    if (bcd_q[39:32] != 8'd0) begin
                        ovf_q <= 1'b1;
                        buf_q <= {8{DASH_DIGIT}};
                    end else begin
                        ovf_q <= 1'b0;
                        buf_q <= bcd_q[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Scan divider and digit index; free-running regardless of FSM state
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            idx_q <= idx_q + 3'd1;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

`ifdef DISPLAY_LZB_EN
    // Blank every digit above the most significant nonzero one (never digit 0,
    // never while showing the overflow dashes)
    always_comb begin
        logic all_zero;
        blank    = '0;
        all_zero = !ovf_q;
        for (int i = 7; i >= 1; i--) begin
            all_zero = all_zero && (buf_q[4*i +: 4] == 4'd0);
            blank[i] = all_zero;
        end
    end
`else
    // No blanking: all digits always shown
    always_comb begin
        blank = '0;
    end
`endif

    // Registered anode and segment drive
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
        end else begin
            an  <= ~(8'd1 << idx_q);
            seg <= blank[idx_q] ? 7'h7F : seg_code(cur_digit);
        end
    end

endmodule

// File: tb/tb_operand_display.sv
`timescale 1ns/1ps
module tb_operand_display;

    localparam int SCAN_DIV = 4;
    localparam logic [6:0] SEG_TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [31:0] value = '0;
    logic        busy;
    logic        overflow;
    logic [6:0]  seg;
    logic [7:0]  an;

    int checks = 0;
    int errors = 0;

    operand_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .clear    (clear),
        .value    (value),
        .load     (load),
        .busy     (busy),
        .overflow (overflow),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    // Reference: decimal digit d of v by plain arithmetic
    function automatic logic [6:0] ref_seg(input logic [31:0] v, input int d);
        longint unsigned vv;
        longint unsigned pow;
        vv  = v;
        pow = 1;
        for (int k = 0; k < d; k++) pow = pow * 10;
        if (vv > 64'd99999999) return 7'h3F;
`ifdef DISPLAY_LZB_EN
        if (d > 0 && vv < pow) return 7'h7F;
`endif
        return SEG_TBL[int'((vv / pow) % 10)];
    endfunction

    // Observe one full frame and compare each digit to the reference
    task automatic check_frame(input string name, input logic [31:0] v);
        logic [6:0] got [8];
        bit         seen [8];
        logic [7:0] onehot;
        for (int d = 0; d < 8; d++) begin
            seen[d] = 1'b0;
            got[d]  = '0;
        end
        for (int c = 0; c < 8*SCAN_DIV + 2; c++) begin
            @(negedge clk);
            for (int d = 0; d < 8; d++) begin
                onehot = 8'd1 << d;
                if (an == ~onehot) begin
                    got[d]  = seg;
                    seen[d] = 1'b1;
                end
            end
        end
        for (int d = 0; d < 8; d++) begin
            checks++;
            if (!seen[d]) begin
                errors++;
                $display("FAIL %s digit%0d: anode never active", name, d);
            end else if (got[d] !== ref_seg(v, d)) begin
                errors++;
                $display("FAIL %s digit%0d: seg=%h expected %h", name, d, got[d], ref_seg(v, d));
            end
        end
    endtask

    // Must be called at a negedge; returns with busy low (or budget spent)
    task automatic do_load(input logic [31:0] v, output int bcnt);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 60 && busy; i++) begin
            bcnt++;
            @(negedge clk);
        end
    endtask

    task automatic check_conv(input string name, input logic [31:0] v);
        int bcnt;
        logic exp_ovf;
        exp_ovf = (v > 32'd99999999);
        do_load(v, bcnt);
        checks++;
        if (bcnt !== 33) begin
            errors++;
            $display("FAIL %s busy_len: got %0d expected 33", name, bcnt);
        end
        checks++;
        if (overflow !== exp_ovf) begin
            errors++;
            $display("FAIL %s overflow: got %b expected %b", name, overflow, exp_ovf);
        end
        check_frame(name, v);
    endtask

    task automatic test_reset();
        repeat (6) @(negedge clk);
        #2 clear = 1'b0;
        #1;
        checks += 4;
        if (an !== 8'hFF)    begin errors++; $display("FAIL reset_an: got %h expected ff", an); end
        if (seg !== 7'h7F)   begin errors++; $display("FAIL reset_seg: got %h expected 7f", seg); end
        if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 8'hFF) begin errors++; $display("FAIL reset_hold_an: got %h expected ff", an); end
        clear = 1'b1;
        @(negedge clk);
        checks += 2;
        if (an !== 8'hFE)  begin errors++; $display("FAIL release_an: got %h expected fe", an); end
        if (seg !== 7'h40) begin errors++; $display("FAIL release_seg: got %h expected 40", seg); end
        check_frame("reset_frame", 32'd0);
    endtask

    task automatic test_convert();
        logic [31:0] v;
        check_conv("conv_12345", 32'd12345);
        for (int n = 0; n < 8; n++) begin
            case ($urandom_range(0, 2))
                0:       v = $urandom_range(0, 999);
                1:       v = $urandom_range(0, 99999999);
                default: v = $urandom();
            endcase
            check_conv("conv_rand", v);
        end
    endtask

    task automatic test_overflow();
        check_conv("ovf_1e8", 32'd100000000);
        check_conv("ovf_max", 32'hFFFFFFFF);
        check_conv("max_ok", 32'd99999999);
    endtask

    task automatic test_load_while_busy();
        int bcnt;
        value = 32'd7;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            bcnt++;
            if (i == 4) begin
                value = 32'd9;
                load  = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        checks++;
        if (bcnt !== 33) begin errors++; $display("FAIL busy_load_len: got %0d expected 33", bcnt); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_load_queued: busy=%b expected 0", busy); end
        check_frame("busy_load_frame", 32'd7);
    endtask

    task automatic test_reset_mid();
        value = 32'd555;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (10) @(negedge clk);
        #2 clear = 1'b0;
        #1;
        checks += 2;
        if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf: got %b expected 0", overflow); end
        @(negedge clk);
        clear = 1'b1;
        check_frame("midrst_frame", 32'd0);
        check_conv("after_midrst_8", 32'd8);
    endtask

    task automatic test_scan_wrap();
        logic [7:0] prev;
        logic [7:0] exp_an;
        logic [31:0] sv;
        bit found;
        int bcnt;
        sv    = $urandom_range(0, 99999999);
        found = 1'b0;
        for (int i = 0; i < 8*SCAN_DIV + 8; i++) begin
            prev = an;
            @(negedge clk);
            if (an == 8'hFE && prev != 8'hFE) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL scan_start: an=%h never entered fe", an);
        end else begin
            for (int k = 0; k < 9; k++) begin
                for (int j = 0; j < SCAN_DIV; j++) begin
                    if (!(k == 0 && j == 0)) @(negedge clk);
                    exp_an = ~(8'd1 << (k % 8));
                    checks++;
                    if (an !== exp_an) begin
                        errors++;
                        $display("FAIL scan_seq k%0d j%0d: an=%h expected %h", k, j, an, exp_an);
                    end
                    if (k == 1 && j == 0) begin
                        value = sv;
                        load  = 1'b1;
                    end else begin
                        load = 1'b0;
                    end
                end
            end
        end
        load = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 60 && busy; i++) begin
            bcnt++;
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL scan_conv_done: busy still high"); end
        if (found) check_frame("scan_conv_frame", sv);
    endtask

    initial begin
        clear = 1'b0;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        test_reset();
        test_convert();
        test_overflow();
        test_load_while_busy();
        test_reset_mid();
        test_scan_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
